jk_universal_register: RTL
==========================

# jk_universal_register

Parametrised WIDTH-bit universal register in which every storage bit is a JK flip-flop cell. Per-bit J/K inputs are derived from the requested next state. It generalises the single-bit D-from-JK flip-flop to a multi-bit register with eight operating modes: hold, load, shift both ways, increment, decrement, masked toggle and clear. It sits wherever the design needs a loadable counter, shifter or toggle register built from the team's JK cell, and it is the next step in the flip-flop series.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 1.
- RESET_VALUE, '0, value loaded into q by reset; WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; 0 forces hold.
- mode  input  3  operation select (encoding under Operation).
- d  input  WIDTH  parallel load data, or toggle mask in TOGGLE mode.
- ser_in  input  1  serial input for the shift modes.
- q  output  WIDTH  register contents.
- ser_out  output  1  bit shifted out by the current shift mode.
- tc  output  1  terminal count for the current count mode.

## Operation
- One clock and one asynchronous, active-low reset. While rst = 0, q = RESET_VALUE, ser_out = 0 and tc = 0, independent of clk.
- Mode encoding and next state n:
  - 0 HOLD: n = q.
  - 1 LOAD: n = d.
  - 2 SHL: n = {q[WIDTH-2:0], ser_in}.
  - 3 SHR: n = {ser_in, q[WIDTH-1:1]}.
  - 4 INC: n = q + 1, modulo 2^WIDTH.
  - 5 DEC: n = q − 1, modulo 2^WIDTH.
  - 6 TOGGLE: n = q ^ d.
  - 7 CLEAR: n = 0, not RESET_VALUE.
- en = 0 forces n = q for every mode value.
- Per bit i, the JK drive is J_i = n_i & ~q_i and K_i = ~n_i & q_i. Each cell therefore sees only set, reset or hold, never J = K = 1.
- WIDTH = 1: SHL and SHR both give n = ser_in.
- ser_out is combinational:
  - q[WIDTH-1] when en = 1 and mode = SHL.
  - q[0] when en = 1 and mode = SHR.
  - 0 otherwise.
- tc is combinational:
  - 1 when en = 1, mode = INC and q is all ones.
  - 1 when en = 1, mode = DEC and q is all zeros.
  - 0 otherwise.
- Wrap-around:
  - INC from all ones gives 0, with tc = 1 during that cycle.
  - DEC from 0 gives all ones, with tc = 1 during that cycle.
- Arithmetic is unsigned, WIDTH bits wide. Carry beyond WIDTH is discarded, and tc is the only indication of it.

## Timing
- q updates on the rising clk edge. Latency is 1 cycle from inputs sampled to the new q.
- There is no handshake. en, mode, d and ser_in must be stable around the rising edge.
- ser_out and tc are valid in the same cycle as the inputs that select them. They are zero-latency combinational paths.
- Reset asserted mid-operation: q goes to RESET_VALUE immediately, and any in-flight operation is discarded.
- Reset release: the first rising edge after rst returns to 1 performs the selected operation on RESET_VALUE.
- Reset released on the same edge as a mode change: the edge after release uses the mode present at that edge.

## Structure
- Package jk_reg_pkg holds:
  - the 3-bit mode enumeration (HOLD … CLEAR);
  - the mode-width constant.
- Sub-module jk_cell:
  - one JK flip-flop with ports clk, rst, j, k, rst_val, q;
  - asynchronous active-low reset to rst_val;
  - J/K truth table: 00 hold, 01 reset, 10 set, 11 toggle.
- Top level instantiates WIDTH jk_cell instances with a generate loop. It also contains the combinational next-state multiplexer, J/K derivation, ser_out and tc logic.

## Test plan
- Reset: WIDTH = 8, RESET_VALUE = 8'hA5, rst = 0 mid-cycle → q = 8'hA5 immediately, ser_out = 0, tc = 0. Then CLEAR → q = 8'h00.
- LOAD then TOGGLE: load d = 8'h3C → q = 8'h3C. Next cycle TOGGLE with d = 8'hFF → q = 8'hC3. Then en = 0 with mode = LOAD → q stays 8'hC3.
- INC wrap: load 8'hFE, INC for 3 cycles → q = 8'hFF, 8'h00, 8'h01. tc = 1 only in the cycle where q = 8'hFF.
- DEC wrap: load 8'h01, DEC for 2 cycles → q = 8'h00, 8'hFF. tc = 1 only in the cycle where q = 8'h00.
- Shifts:
  - Load 8'h81, SHL with ser_in = 0 → ser_out = 1 before the edge, q = 8'h02 after it.
  - Load 8'h81, SHR with ser_in = 1 → ser_out = 1 before the edge, q = 8'hC0 after it.
  - WIDTH = 1 instance: SHR with ser_in = 1 → q = 1.
- Reset mid-count: INC running from 8'h10 → drop rst for 3 ns between edges → q = RESET_VALUE at once. After release, the first edge gives RESET_VALUE + 1.

Source files
------------

// File: rtl/jk_reg_pkg.sv
// Shared definitions for the JK-based universal register: mode encoding and widths.
package jk_reg_pkg;

    // Width of the operation-select field
    localparam int MODE_W = 3;

    // Operation modes; the numeric values are the external mode encoding
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD   = 3'd0,
        MODE_LOAD   = 3'd1,
        MODE_SHL    = 3'd2,
        MODE_SHR    = 3'd3,
        MODE_INC    = 3'd4,
        MODE_DEC    = 3'd5,
        MODE_TOGGLE = 3'd6,
        MODE_CLEAR  = 3'd7
    } mode_e;

    // J/K drive that moves a cell from its current value to the wanted value.
    // Only set, reset or hold is ever requested, so j and k are never both 1.
    function automatic logic [1:0] jk_drive(input logic next_bit, input logic cur_bit);
        logic j;
        logic k;
        j = next_bit & ~cur_bit;
        k = ~next_bit & cur_bit;
        return {j, k};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to a per-cell value.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    // JK truth table: 00 hold, 01 reset, 10 set, 11 toggle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= rst_val;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_universal_register.sv
// WIDTH-bit universal register (hold/load/shift/count/toggle/clear) built
// from JK cells; each cell is driven towards a combinationally chosen next state.
module jk_universal_register
    import jk_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode_sel;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;

    assign mode_sel = mode_e'(mode);

    // Shift values built bit by bit so that WIDTH = 1 collapses to ser_in
    always_comb begin
        shl_val    = '0;
        shr_val    = '0;
        shl_val[0] = ser_in;
        shr_val[WIDTH-1] = ser_in;
        for (int i = 1; i < WIDTH; i++) begin
            shl_val[i]   = q[i-1];
            shr_val[i-1] = q[i];
        end
    end

    // Next-state multiplexer; en = 0 holds regardless of mode
    always_comb begin
        next_q = q;
        if (en) begin
            case (mode_sel)
                MODE_HOLD:   next_q = q;
                MODE_LOAD:   next_q = d;
                MODE_SHL:    next_q = shl_val;
                MODE_SHR:    next_q = shr_val;
                MODE_INC:    next_q = q + ONE;
                MODE_DEC:    next_q = q - ONE;
                MODE_TOGGLE: next_q = q ^ d;
                MODE_CLEAR:  next_q = '0;
                default:     next_q = q;
            endcase
        end
    end

    // Per-bit J/K derivation from the requested transition
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_drive(next_q[i], q[i]);
        end
    end

    // Storage: one JK cell per bit, each reset to its bit of RESET_VALUE
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .j       (j[gi]),
            .k       (k[gi]),
            .rst_val (RESET_VALUE[gi]),
            .q       (q[gi])
        );
    end

    // Serial output: the bit about to leave in the active shift direction;
    // forced low while reset is asserted
    always_comb begin
        ser_out = 1'b0;
        if (rst && en) begin
            if (mode_sel == MODE_SHL) begin
                ser_out = q[WIDTH-1];
            end else if (mode_sel == MODE_SHR) begin
                ser_out = q[0];
            end
        end
    end

    // Terminal count: flags the cycle in which the counter wraps
    always_comb begin
        tc = 1'b0;
        if (rst && en) begin
            if (mode_sel == MODE_INC) begin
                tc = &q;
            end else if (mode_sel == MODE_DEC) begin
                tc = ~|q;
            end
        end
    end

endmodule
